dsm_bitstream_decimator: RTL and testbench
==========================================

// Module: dsm_bitstream_decimator
// PURPOSE
//  Recovers the 16-bit fractional word from the 1-bit bitstream of the
//  first-order digital delta-sigma modulator in the fractional-N PLL.
//  Counts ones over a fixed boxcar window of 2^WIN_LOG2 qualified bits,
//  scales the count to W bits and presents it through a valid/ready port.
//  Used in loopback checking and in the on-chip fraction monitor.
// PARAMETERS
//  W         16  width of recovered fraction (matches modulator alpha width)
//  WIN_LOG2  16  log2 of window length in qualified bits; legal 1..W
//  SKIP       0  qualified bits discarded after rst/clear (modulator settling)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  clear      in   1        synchronous restart: abort window, re-enter SKIP
//  bit_in     in   1        modulator output bit (MSB)
//  bit_valid  in   1        bit_in qualified this cycle
//  est_out    out  W        recovered fraction estimate
//  est_valid  out  1        est_out holds an unconsumed result
//  est_ready  in   1        consumer accepts est_out when est_valid&est_ready
//  overrun    out  1        sticky: an unconsumed result was overwritten
// BEHAVIOUR
//  - Reset (rst=1 at edge): est_out=0, est_valid=0, overrun=0,
//    ones counter=0, bit counter=0. FSM enters SKIP if SKIP>0, else ACQ.
//  - clear: same as rst for counters and FSM. est_out and est_valid are
//    unchanged. overrun clears. clear wins over a bit_valid in the same cycle.
//  - FSM SKIP: each qualified bit increments skip_cnt, and bit_in is ignored.
//    After the SKIP-th qualified bit -> ACQ. SKIP is never re-entered
//    without rst/clear.
//  - FSM ACQ: each qualified bit adds bit_in to ones (WIN_LOG2+1 bits) and
//    increments bit_cnt (WIN_LOG2 bits, wraps).
//  - Cycles with bit_valid=0 change no counter.
//  - Window close: on the edge that accepts the 2^WIN_LOG2-th qualified bit,
//    with that bit included:
//    est_out <= sat(ones_next << (W-WIN_LOG2)), est_valid <= 1,
//    and ones/bit_cnt <= 0. The FSM stays in ACQ; windows are back-to-back
//    with no gap.
//  - Latency: est_valid is high in the cycle after the closing bit's edge.
//  - Saturation: ones_next = 2^WIN_LOG2 (all ones) -> est_out = 2^W-1.
//    No other scaled value exceeds the range.
//  - Handshake: est_valid&est_ready at an edge with no window close ->
//    est_valid <= 0. est_out holds its value until the next result.
//  - Simultaneous close + consume: est_out gets the new value,
//    est_valid stays 1, no overrun.
//  - Close while est_valid=1 and est_ready=0: est_out overwritten with the
//    new value, est_valid stays 1, overrun <= 1 (sticky until rst/clear).
//  - est_out and est_valid are registered and change only at clk edges.
//    Inputs have no combinational path to outputs.
// TESTING (W=16 unless noted)
//  1. WIN_LOG2=4, 16 qualified zeros -> est_valid on cycle after 16th bit,
//     est_out=0x0000.
//  2. WIN_LOG2=4, 16 qualified ones -> est_out=0xFFFF (saturated);
//     next window starts at ones=0.
//  3. WIN_LOG2=4, pattern 1,0 repeated, bit_valid toggling 1/0 -> 8 ones
//     counted -> est_out=0x8000; gaps not counted.
//  4. WIN_LOG2=16, SKIP=8, first-order DSM model with alpha=0x4000 ->
//     est_out within 0x4000+/-1 every window.
//  5. WIN_LOG2=4, est_ready=0 over two windows (ones=3 then 5) ->
//     est_out=0x5000, overrun=1; then clear -> overrun=0, est_valid stays 1.
//  6. rst after 7 bits of a window -> all outputs 0; next 16 qualified bits
//     form a full window. Also close+consume in same cycle -> est_valid
//     stays 1, overrun=0.

Source files
------------

// File: rtl/dsm_bitstream_decimator.sv
// dsm_bitstream_decimator
// Boxcar ones-counter that recovers the W-bit fraction from a first-order
// delta-sigma bitstream. A window of 2^WIN_LOG2 qualified bits is counted,
// scaled up to W bits (saturating at full scale) and handed out through a
// valid/ready port with a sticky overrun flag.
module dsm_bitstream_decimator #(
   parameter int unsigned W        = 16,
   parameter int unsigned WIN_LOG2 = 16,
   parameter int unsigned SKIP     = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clear,
   input  logic         i_bit_in,
   input  logic         i_bit_valid,
   output logic [W-1:0] o_est_out,
   output logic         o_est_valid,
   input  logic         i_est_ready,
   output logic         o_overrun
);

   typedef enum logic {
      ST_SKIP,
      ST_ACQ
   } state_t;

   localparam state_t ST_INIT = (SKIP > 0) ? ST_SKIP : ST_ACQ;
   localparam int unsigned SKW = (SKIP > 1) ? $clog2(SKIP) : 1;
   localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);

   state_t                r_state;
   state_t                w_state_next;
   logic [SKW-1:0]        r_skip_cnt;
   logic [WIN_LOG2:0]     r_ones;
   logic [WIN_LOG2-1:0]   r_bit_cnt;
   logic [W-1:0]          r_est_out;
   logic                  r_est_valid;
   logic                  r_overrun;

   logic                  w_skip_inc;
   logic                  w_acq;
   logic                  w_close;
   logic [WIN_LOG2:0]     w_ones_next;
   logic [W:0]            w_ones_ext;
   logic [W:0]            w_scaled_full;
   logic [W-1:0]          w_scaled;

   // Ones count including the current bit, and its scaled/saturated result.
   // Only a completely full window (count == 2^WIN_LOG2) can reach bit W.
   assign w_ones_next   = r_ones + (WIN_LOG2 + 1)'(i_bit_in);
   assign w_ones_ext    = (W + 1)'(w_ones_next);
   assign w_scaled_full = w_ones_ext << (W - WIN_LOG2);
   assign w_scaled      = w_scaled_full[W] ? '1 : w_scaled_full[W-1:0];
   assign w_close       = w_acq && (r_bit_cnt == '1);

   // FSM state register; rst and clear both restart settling.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) r_state <= ST_INIT;
      else                  r_state <= w_state_next;
   end

   // Next state: leave SKIP on the last discarded qualified bit.
   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_SKIP && i_bit_valid && r_skip_cnt == SKIP_LAST)
         w_state_next = ST_ACQ;
   end

   // FSM outputs: which counter a qualified bit advances.
   always_comb begin
      w_skip_inc = 1'b0;
      w_acq      = 1'b0;
      if (i_bit_valid) begin
         if (r_state == ST_SKIP) w_skip_inc = 1'b1;
         else                    w_acq      = 1'b1;
      end
   end

   // Skip, ones and bit counters; a closing bit restarts the next window at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_skip_cnt <= '0;
         r_ones     <= '0;
         r_bit_cnt  <= '0;
      end else begin
         if (w_skip_inc) r_skip_cnt <= r_skip_cnt + 1'b1;
         if (w_acq) begin
            if (w_close) begin
               r_ones    <= '0;
               r_bit_cnt <= '0;
            end else begin
               r_ones    <= w_ones_next;
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
      end
   end

   // Result register, valid/ready handshake and sticky overrun.
   // clear leaves the held result and its valid untouched.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_est_out   <= '0;
         r_est_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else if (i_clear) begin
         r_overrun   <= 1'b0;
      end else if (w_close) begin
         r_est_out   <= w_scaled;
         r_est_valid <= 1'b1;
         if (r_est_valid && !i_est_ready) r_overrun <= 1'b1;
      end else if (r_est_valid && i_est_ready) begin
         r_est_valid <= 1'b0;
      end
   end

   assign o_est_out   = r_est_out;
   assign o_est_valid = r_est_valid;
   assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_dsm_bitstream_decimator.sv
// Directed bench for dsm_bitstream_decimator: a short-window instance
// (WIN_LOG2=4) for the handshake/boundary scenarios and a full-width
// instance (WIN_LOG2=16, SKIP=8) fed by a first-order DSM model.
module tb_dsm_bitstream_decimator;

   logic        clk;
   int unsigned checks;
   int unsigned errors;

   // Short-window instance signals
   logic        rst, clear, bit_in, bit_valid, est_ready;
   logic [15:0] est_out;
   logic        est_valid, overrun;

   // Full-window instance signals
   logic        rst_b, clear_b, bit_in_b, bit_valid_b, est_ready_b;
   logic [15:0] est_out_b;
   logic        est_valid_b, overrun_b;

   dsm_bitstream_decimator #(.W(16), .WIN_LOG2(4), .SKIP(0)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_bit_in(bit_in),
      .i_bit_valid(bit_valid), .o_est_out(est_out), .o_est_valid(est_valid),
      .i_est_ready(est_ready), .o_overrun(overrun)
   );

   dsm_bitstream_decimator #(.W(16), .WIN_LOG2(16), .SKIP(8)) dut16 (
      .i_clk(clk), .i_rst(rst_b), .i_clear(clear_b), .i_bit_in(bit_in_b),
      .i_bit_valid(bit_valid_b), .o_est_out(est_out_b), .o_est_valid(est_valid_b),
      .i_est_ready(est_ready_b), .o_overrun(overrun_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock on the short instance; inputs return to idle #1 after the edge.
   task automatic step(input logic b, input logic v, input logic r);
      bit_in = b; bit_valid = v; est_ready = r;
      @(posedge clk); #1;
      bit_in = 1'b0; bit_valid = 1'b0; est_ready = 1'b0;
   endtask

   // Push n qualified bits taken LSB-first from pattern, ready low.
   task automatic push_bits(input int unsigned n, input logic [31:0] pattern);
      for (int unsigned i = 0; i < n; i++) step(pattern[i], 1'b1, 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      checks++;
      if (est_out !== 16'h0000 || est_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset: est_out=%h valid=%b overrun=%b required 0000/0/0", est_out, est_valid, overrun);
      end
   endtask

   task automatic test_zeros;
      push_bits(15, 32'h0);
      checks++;
      if (est_valid !== 1'b0) begin
         errors++; $display("FAIL zeros_early: valid=%b required 0", est_valid);
      end
      push_bits(1, 32'h0);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h0000) begin
         errors++; $display("FAIL zeros_close: valid=%b est=%h required 1/0000", est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (est_valid !== 1'b0 || est_out !== 16'h0000) begin
         errors++; $display("FAIL zeros_consume: valid=%b est=%h required 0/0000", est_valid, est_out);
      end
   endtask

   task automatic test_saturate;
      push_bits(16, 32'hFFFF);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'hFFFF) begin
         errors++; $display("FAIL saturate: valid=%b est=%h required 1/ffff", est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
      push_bits(16, 32'h0);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h0000) begin
         errors++; $display("FAIL after_saturate: valid=%b est=%h required 1/0000", est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_gaps;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i == 30) begin
            checks++;
            if (est_valid !== 1'b0) begin
               errors++; $display("FAIL gaps_early: valid=%b required 0", est_valid);
            end
         end
         // qualified bits on even cycles: 1,0,1,0...; gap cycles carry bit_in=1
         if (i % 2 == 0) step(((i / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
         else            step(1'b1, 1'b0, 1'b0);
      end
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h8000) begin
         errors++; $display("FAIL gaps: valid=%b est=%h required 1/8000", est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_overrun;
      push_bits(16, 32'h0007);
      checks++;
      if (est_out !== 16'h3000 || est_valid !== 1'b1 || overrun !== 1'b0) begin
         errors++; $display("FAIL overrun_first: est=%h valid=%b ovr=%b required 3000/1/0", est_out, est_valid, overrun);
      end
      push_bits(16, 32'h001F);
      checks++;
      if (est_out !== 16'h5000 || est_valid !== 1'b1 || overrun !== 1'b1) begin
         errors++; $display("FAIL overrun_second: est=%h valid=%b ovr=%b required 5000/1/1", est_out, est_valid, overrun);
      end
      // clear together with a qualified one: the bit must be dropped
      clear = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      clear = 1'b0;
      checks++;
      if (overrun !== 1'b0 || est_valid !== 1'b1 || est_out !== 16'h5000) begin
         errors++; $display("FAIL clear: ovr=%b valid=%b est=%h required 0/1/5000", overrun, est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
      push_bits(15, 32'h0);
      checks++;
      if (est_valid !== 1'b0) begin
         errors++; $display("FAIL clear_window_early: valid=%b required 0", est_valid);
      end
      push_bits(1, 32'h0);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h0000) begin
         errors++; $display("FAIL clear_window: valid=%b est=%h required 1/0000", est_valid, est_out);
      end
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_mid_reset;
      push_bits(16, 32'h00FF);
      push_bits(7, 32'h7F);
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      checks++;
      if (est_out !== 16'h0000 || est_valid !== 1'b0 || overrun !== 1'b0) begin
         errors++; $display("FAIL mid_reset: est=%h valid=%b ovr=%b required 0000/0/0", est_out, est_valid, overrun);
      end
      push_bits(15, 32'h000F);
      checks++;
      if (est_valid !== 1'b0) begin
         errors++; $display("FAIL mid_reset_early: valid=%b required 0", est_valid);
      end
      push_bits(1, 32'h0);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h4000) begin
         errors++; $display("FAIL mid_reset_window: valid=%b est=%h required 1/4000", est_valid, est_out);
      end
   endtask

   task automatic test_back_to_back;
      // result 0x4000 still pending; next window (6 ones) closes while consumed
      push_bits(15, 32'h003F);
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (est_valid !== 1'b1 || est_out !== 16'h6000 || overrun !== 1'b0) begin
         errors++; $display("FAIL close_consume: valid=%b est=%h ovr=%b required 1/6000/0", est_valid, est_out, overrun);
      end
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if (est_valid !== 1'b0 || est_out !== 16'h6000) begin
         errors++; $display("FAIL hold_after_consume: valid=%b est=%h required 0/6000", est_valid, est_out);
      end
   endtask

   task automatic test_dsm;
      logic [15:0] acc;
      logic [16:0] sum;
      acc = '0;
      rst_b = 1'b1;
      @(posedge clk); #1;
      rst_b = 1'b0;
      bit_valid_b = 1'b1;
      for (int unsigned i = 0; i < 8 + 65536; i++) begin
         sum = {1'b0, acc} + 17'h04000;
         acc = sum[15:0];
         bit_in_b = sum[16];
         if (i == 8 + 65535) begin
            checks++;
            if (est_valid_b !== 1'b0) begin
               errors++; $display("FAIL dsm_early: valid=%b required 0", est_valid_b);
            end
         end
         @(posedge clk); #1;
      end
      bit_valid_b = 1'b0;
      checks++;
      if (est_valid_b !== 1'b1 || est_out_b < 16'h3FFF || est_out_b > 16'h4001) begin
         errors++; $display("FAIL dsm_window: valid=%b est=%h required 1/4000+-1", est_valid_b, est_out_b);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; clear = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; est_ready = 1'b0;
      rst_b = 1'b0; clear_b = 1'b0; bit_in_b = 1'b0; bit_valid_b = 1'b0; est_ready_b = 1'b0;
      test_reset;
      test_zeros;
      test_saturate;
      test_gaps;
      test_overrun;
      test_mid_reset;
      test_back_to_back;
      test_dsm;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
